pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM capture and decode block: the receive-side counterpart of the team's PWM generator. It samples an asynchronous PWM input, measures high time and period in system clock cycles, and quantises the duty cycle to a 3-bit code in the generator's speed-code space. It sits in the Tiny Tapeout user design next to the generator, so a board loopback or an external PWM source can be checked on-chip.

## Interface
Parameters:
- CNT_W, 16, width of the high-time/period counters and result registers (≥4)
- SYNC_STAGES, 2, synchroniser depth on pwm_in (≥2)

Ports:
- clk  in  1  system clock; one clock domain, all state on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  block enable; low = synchronous clear to IDLE
- pwm_in  in  1  asynchronous PWM input
- high_time  out  CNT_W  clk cycles pwm_in was high in the last complete period
- period  out  CNT_W  clk cycles between the last two rising edges
- duty_code  out  3  floor(8·high_time/period), range 0..7
- valid  out  1  one-cycle pulse: new high_time/period/duty_code
- stuck  out  1  level: no rising edge for 2^CNT_W−1 cycles

## Operation
- pwm_in passes through SYNC_STAGES flops. rise = s & ~s_d and fall = ~s & s_d, where s is the synchroniser output and s_d is s delayed one cycle.
- States are IDLE, MEASURE and STUCK; reset and ena=0 both enter IDLE.
- IDLE:
  - on rise: cnt_p←1, cnt_h←1, go to MEASURE, no valid.
  - otherwise cnt_p increments; at all-ones, go to STUCK.
- MEASURE:
  - cnt_p increments every cycle.
  - cnt_h increments while s=1 and freezes after fall.
  - on rise: period←cnt_p, high_time←cnt_h, duty_code←f(cnt_h,cnt_p), valid=1 for one cycle; then cnt_p←1, cnt_h←1.
  - if cnt_p reaches all-ones before a rise: go to STUCK, no valid.
- STUCK:
  - stuck=1; result registers hold their last values.
  - on rise: stuck←0, cnt_p←1, cnt_h←1, go to MEASURE. This rise produces no valid.
- Duty code: duty_code = number of k∈{1..7} with 8·cnt_h ≥ k·cnt_p. Compare at CNT_W+3 bits with no truncation; no divider.
- 0 % and 100 % duty produce no rising edge, so the block ends in STUCK and never raises valid.
- Counters saturate and never wrap.
- ena=0 clears state, counters, outputs and stuck on the next clk edge. The synchroniser keeps running.

## Timing
- Reset values: high_time=0, period=0, duty_code=0, valid=0, stuck=0, state=IDLE.
- All outputs are registered.
- Latency: valid is high for one cycle, SYNC_STAGES+1 clk edges after the first edge that samples the new pwm_in high level.
- high_time, period and duty_code change in the same cycle valid rises, then hold until the next valid, ena=0 or reset.
- First valid comes on the second rising edge after reset, ena, or leaving STUCK.
- Minimum measurable waveform: high ≥2 and low ≥2 clk cycles; shorter pulses may be missed.
- Asynchronous reset mid-period: outputs are zero immediately and the partial measurement is discarded.

## Structure
- Shared package pwm_pkg holds:
  - the state typedef (IDLE, MEASURE, STUCK)
  - DUTY_W=3, the same width as the generator speed code
  - the default CNT_W constant
- Sub-module pwm_sync_edge holds the SYNC_STAGES synchroniser plus the rise/fall detector.
- pwm_capture holds the FSM, counters and duty quantiser.

## Test plan
- Period 10, high 3, repeated: the second rise gives valid with period=10, high_time=3, duty_code=2; valid pulses every 10 cycles after that.
- Period 8, high 4: period=8, high_time=4, duty_code=4. Then switch to period 20, high 15: the next valid gives period=20, high_time=15, duty_code=6.
- CNT_W=8, pwm_in held low after reset: stuck=1 after 255 cycles and valid never rises. Then start period 10, high 5: first rise clears stuck with no valid; the next rise gives valid with duty_code=4.
- Period 10, high 9, then pwm_in held high: duty_code=7; stuck asserts after 2^CNT_W−1 cycles while results hold their last values.
- Assert rst_n low mid-high-phase: all outputs are 0 immediately; after release, the first valid comes only on the second rise.
- ena=0 for 3 cycles mid-stream: outputs clear and state returns to IDLE; after ena=1, valid resumes on the second rise with correct values.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair: FSM state
// encoding, duty-code width and the default counter width.
package pwm_pkg;

  // Duty code width matches the generator speed code.
  localparam int DUTY_W      = 3;
  // Number of quantisation levels represented by the duty code.
  localparam int DUTY_LEVELS = 1 << DUTY_W;
  // Default width of the high-time / period counters.
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchroniser for the asynchronous PWM input followed by a rise/fall
// detector on the synchronised level.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   level_d_r;

  // Shift pwm_in through the synchroniser chain and keep a one-cycle
  // delayed copy of the synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r    <= {SYNC_STAGES{1'b0}};
      level_d_r <= 1'b0;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], pwm_in};
      level_d_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = sync_r[SYNC_STAGES-1] & ~level_d_r;
  assign fall  = ~sync_r[SYNC_STAGES-1] & level_d_r;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture and decode: measures high time and period of pwm_in in clk
// cycles and quantises the duty cycle to a 3-bit code. A missing rising
// edge for a full counter range is reported as stuck.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_time,
  output logic [CNT_W-1:0]  period,
  output logic [DUTY_W-1:0] duty_code,
  output logic              valid,
  output logic              stuck
);

  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX_M1 = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [DUTY_W-1:0] DUTY_ZERO  = {DUTY_W{1'b0}};
  localparam logic [DUTY_W-1:0] DUTY_ONE   = {{(DUTY_W-1){1'b0}}, 1'b1};

  // Duty code = count of k in 1..7 with 8*h >= k*p. The thresholds k*p are
  // built by repeated addition at CNT_W+3 bits so nothing truncates and no
  // multiplier or divider is needed.
  function automatic logic [DUTY_W-1:0] duty_quant(
    input logic [CNT_W-1:0] h,
    input logic [CNT_W-1:0] p
  );
    logic [CNT_W+2:0]  h8;
    logic [CNT_W+2:0]  p_ext;
    logic [CNT_W+2:0]  thresh;
    logic [DUTY_W-1:0] code;
    h8     = {h, 3'b000};
    p_ext  = {3'b000, p};
    thresh = {(CNT_W+3){1'b0}};
    code   = DUTY_ZERO;
    for (int k = 1; k < DUTY_LEVELS; k++) begin
      thresh = thresh + p_ext;
      if (h8 >= thresh) begin
        code = code + DUTY_ONE;
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

  logic              level_s;
  logic              rise_s;
  logic              fall_s;
  logic              srst_s;
  logic [DUTY_W-1:0] duty_s;

  pwm_state_e        state_r;
  logic [CNT_W-1:0]  cnt_p_r;
  logic [CNT_W-1:0]  cnt_h_r;
  logic              h_frozen_r;
  logic [CNT_W-1:0]  high_time_r;
  logic [CNT_W-1:0]  period_r;
  logic [DUTY_W-1:0] duty_code_r;
  logic              valid_r;
  logic              stuck_r;

  pwm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .level  (level_s),
    .rise   (rise_s),
    .fall   (fall_s)
  );

  // Block disable acts as the synchronous soft clear.
  assign srst_s = ~ena;

  // Quantise the measurement currently held in the counters.
  always_comb begin
    duty_s = duty_quant(cnt_h_r, cnt_p_r);
  end

  // Capture FSM: counters, stuck detection and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_p_r     <= CNT_ZERO;
      cnt_h_r     <= CNT_ZERO;
      h_frozen_r  <= 1'b0;
      high_time_r <= CNT_ZERO;
      period_r    <= CNT_ZERO;
      duty_code_r <= DUTY_ZERO;
      valid_r     <= 1'b0;
      stuck_r     <= 1'b0;
    end else if (srst_s) begin
      state_r     <= IDLE;
      cnt_p_r     <= CNT_ZERO;
      cnt_h_r     <= CNT_ZERO;
      h_frozen_r  <= 1'b0;
      high_time_r <= CNT_ZERO;
      period_r    <= CNT_ZERO;
      duty_code_r <= DUTY_ZERO;
      valid_r     <= 1'b0;
      stuck_r     <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            // First edge only starts a measurement; nothing to report yet.
            cnt_p_r    <= CNT_ONE;
            cnt_h_r    <= CNT_ONE;
            h_frozen_r <= 1'b0;
            state_r    <= MEASURE;
          end else if (cnt_p_r >= CNT_MAX_M1) begin
            cnt_p_r <= CNT_MAX;
            stuck_r <= 1'b1;
            state_r <= STUCK;
          end else begin
            cnt_p_r <= cnt_p_r + CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise_s) begin
            period_r    <= cnt_p_r;
            high_time_r <= cnt_h_r;
            duty_code_r <= duty_s;
            valid_r     <= 1'b1;
            cnt_p_r     <= CNT_ONE;
            cnt_h_r     <= CNT_ONE;
            h_frozen_r  <= 1'b0;
          end else begin
            if (cnt_p_r >= CNT_MAX_M1) begin
              cnt_p_r <= CNT_MAX;
              stuck_r <= 1'b1;
              state_r <= STUCK;
            end else begin
              cnt_p_r <= cnt_p_r + CNT_ONE;
            end
            // High time stops at the first fall so a glitch later in the
            // low phase cannot extend it.
            if (fall_s) begin
              h_frozen_r <= 1'b1;
            end else if (level_s && !h_frozen_r && (cnt_h_r != CNT_MAX)) begin
              cnt_h_r <= cnt_h_r + CNT_ONE;
            end else begin
              cnt_h_r <= cnt_h_r;
            end
          end
        end
        STUCK: begin
          if (rise_s) begin
            // Recovery edge restarts the measurement without a result.
            stuck_r    <= 1'b0;
            cnt_p_r    <= CNT_ONE;
            cnt_h_r    <= CNT_ONE;
            h_frozen_r <= 1'b0;
            state_r    <= MEASURE;
          end else begin
            state_r <= STUCK;
          end
        end
        default: begin
          state_r    <= IDLE;
          cnt_p_r    <= CNT_ZERO;
          cnt_h_r    <= CNT_ZERO;
          h_frozen_r <= 1'b0;
          stuck_r    <= 1'b0;
        end
      endcase
    end
  end

  assign high_time = high_time_r;
  assign period    = period_r;
  assign duty_code = duty_code_r;
  assign valid     = valid_r;
  assign stuck     = stuck_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM waveforms, queues the expected
// result for each measured period and compares when valid pulses.
module tb_pwm_capture;

  localparam int CW   = 8;
  localparam int SYNC = 2;

  typedef struct {
    int per;
    int hi;
    int duty;
    int cyc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          pwm_in;
  logic [CW-1:0] high_time;
  logic [CW-1:0] period;
  logic [2:0]    duty_code;
  logic          valid;
  logic          stuck;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];
  int   armed   = 0;
  int   last_per = 0;
  int   last_hi  = 0;

  pwm_capture #(
    .CNT_W       (CW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .pwm_in    (pwm_in),
    .high_time (high_time),
    .period    (period),
    .duty_code (duty_code),
    .valid     (valid),
    .stuck     (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int duty_model(input int per, input int hi);
    int d;
    d = (8 * hi) / per;
    if (d > 7) d = 7;
    return d;
  endfunction

  // Called right after a falling clk edge: raises pwm_in and, if the
  // previous period was fully observed, queues its expected measurement.
  task automatic drive_rise();
    exp_t e;
    if (armed != 0) begin
      e.per  = last_per;
      e.hi   = last_hi;
      e.duty = duty_model(last_per, last_hi);
      e.cyc  = cyc + SYNC + 1;
      q.push_back(e);
    end
    pwm_in = 1'b1;
  endtask

  task automatic run_period(input int per, input int hi);
    @(negedge clk);
    drive_rise();
    repeat (hi - 1) @(negedge clk);
    @(negedge clk);
    pwm_in = 1'b0;
    repeat (per - hi - 1) @(negedge clk);
    last_per = per;
    last_hi  = hi;
    armed    = 1;
  endtask

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    int   has_exp;
    if (valid === 1'b1) begin
      has_exp = (q.size() > 0) ? 1 : 0;
      check("valid_pending", has_exp, 1);
      if (has_exp != 0) begin
        e = q.pop_front();
        check("period", period, e.per);
        check("high_time", high_time, e.hi);
        check("duty_code", duty_code, e.duty);
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    ena    = 1'b1;
    pwm_in = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_high_time", high_time, 0);
    check("rst_period", period, 0);
    check("rst_duty", duty_code, 0);
    check("rst_valid", valid, 0);
    check("rst_stuck", stuck, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Period 10, high 3
    repeat (5) run_period(10, 3);
    // Period 8 high 4, then period 20 high 15
    repeat (3) run_period(8, 4);
    repeat (2) run_period(20, 15);
    armed = 0;

    // Held low after reset: stuck after 255 cycles, no valid
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (stuck === 1'b1) break;
    end
    check("stuck_low_set", stuck, 1);
    check("stuck_low_cycles", n, 255);
    run_period(10, 5);
    check("stuck_cleared", stuck, 0);
    repeat (2) run_period(10, 5);

    // Period 10 high 9, then held high
    repeat (3) run_period(10, 9);
    @(negedge clk);
    drive_rise();
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (stuck === 1'b1) break;
    end
    check("stuck_high_set", stuck, 1);
    check("stuck_high_window", ((n >= 255) && (n <= 260)) ? 1 : 0, 1);
    check("hold_period", period, 10);
    check("hold_high_time", high_time, 9);
    check("hold_duty", duty_code, 7);
    pwm_in = 1'b0;
    armed  = 0;
    repeat (5) @(negedge clk);
    check("stuck_still", stuck, 1);

    // Reset mid-high-phase
    run_period(16, 8);
    check("stuck_left", stuck, 0);
    run_period(16, 8);
    @(negedge clk);
    drive_rise();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_high_time", high_time, 0);
    check("arst_period", period, 0);
    check("arst_duty", duty_code, 0);
    check("arst_valid", valid, 0);
    check("arst_stuck", stuck, 0);
    repeat (3) @(negedge clk);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    armed = 0;
    repeat (4) @(negedge clk);
    repeat (3) run_period(16, 8);

    // ena low for 3 cycles mid-stream
    repeat (2) run_period(10, 3);
    @(negedge clk);
    drive_rise();
    repeat (2) @(negedge clk);
    @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("ena_high_time", high_time, 0);
    check("ena_period", period, 0);
    check("ena_duty", duty_code, 0);
    check("ena_valid", valid, 0);
    check("ena_stuck", stuck, 0);
    repeat (2) @(negedge clk);
    ena   = 1'b1;
    armed = 0;
    repeat (3) @(negedge clk);
    repeat (3) run_period(10, 3);

    // Let the last pending result arrive
    n = 0;
    while ((q.size() != 0) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
